// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: glyph table,
// segment bit positions and the per-digit resolved display attributes.
package seg7_pkg;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  // Every segment pin including the decimal point; used to flip polarity.
  localparam logic [7:0] SEG_ALL = 8'((1 << SEG_DP) | (1 << SEG_A) | (1 << SEG_B) |
                                      (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E) |
                                      (1 << SEG_F) | (1 << SEG_G));

  // Glyphs as {a,b,c,d,e,f,g}, index = nibble value.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic       mask;
    logic       dp;
    logic       blank;
    logic       lz;
    logic [3:0] bright;
  } type_seg7_cfg_s;

  // Priority: blank, raw byte, leading-zero suppression, hex glyph with dp.
  function automatic logic [7:0] seg7_pattern(
    input logic       blank,
    input logic       mask,
    input logic       lz,
    input logic       dp,
    input logic [7:0] raw,
    input logic [6:0] glyph
  );
    logic [7:0] pat;
    pat = 8'h00;
    if (blank) begin
      pat = 8'h00;
    end else if (mask) begin
      pat = raw;
    end else if (lz) begin
      pat = 8'h00;
    end else begin
      pat[SEG_DP]      = dp;
      pat[SEG_A:SEG_G] = glyph;
    end
    return pat;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment glyph lookup ({a..g}, 1 = lit).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = HEX_GLYPH[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered display settings,
// frame-synchronous apply, leading-zero suppression and PWM brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 200000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [8*NUM_DIGITS-1:0] raw_i,
  input  logic [NUM_DIGITS-1:0]   raw_mask_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_en_i,
  input  logic [3:0]              bright_i,
  input  logic                    wr_en_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o,
  output logic                    busy_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TH_W  = CNT_W + 5;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? SEG_ALL : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [8*NUM_DIGITS-1:0] raw;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz;
    logic [3:0]              bright;
  } disp_set_t;

  disp_set_t             pend_q, pend_d;
  disp_set_t             act_q, act_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic                  busy_q, busy_d;
  logic                  frame_q, frame_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick;
  logic                  frame_end;
  logic                  apply;
  logic                  tail_zero;
  logic [NUM_DIGITS-1:0] lz_sup;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] an_on;
  logic [3:0]            cur_nib;
  logic [7:0]            cur_raw;
  logic [6:0]            cur_glyph;
  type_seg7_cfg_s        cur_cfg;
  logic [TH_W-1:0]       thresh;
  logic                  pwm_on;
  logic [7:0]            pat;

  // Scan timing and frame-boundary apply of the pending set.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    frame_end = tick && (digit_q == DIG_LAST);
    apply     = frame_end && busy_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    digit_d   = digit_q;
    if (tick) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end
    frame_d = frame_end;
    // A write on the apply cycle keeps busy set for the following frame.
    busy_d  = wr_en_i | (busy_q & ~frame_end);

    pend_d = pend_q;
    if (wr_en_i) begin
      pend_d.value  = value_i;
      pend_d.raw    = raw_i;
      pend_d.mask   = raw_mask_i;
      pend_d.dp     = dp_i;
      pend_d.blank  = blank_i;
      pend_d.lz     = lz_en_i;
      pend_d.bright = bright_i;
    end
    act_d = apply ? pend_q : act_q;
  end

  // Resolve the attributes of the digit currently being scanned.
  always_comb begin
    tail_zero = 1'b1;
    lz_sup    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      tail_zero = tail_zero & (act_q.value[4*k +: 4] == 4'h0);
      lz_sup[k] = act_q.lz & tail_zero;
    end

    cur_nib        = '0;
    cur_raw        = '0;
    cur_cfg        = '0;
    an_sel         = '0;
    cur_cfg.bright = act_q.bright;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q == DIG_W'(k)) begin
        cur_nib       = act_q.value[4*k +: 4];
        cur_raw       = act_q.raw[8*k +: 8];
        cur_cfg.mask  = act_q.mask[k];
        cur_cfg.dp    = act_q.dp[k];
        cur_cfg.blank = act_q.blank[k];
        cur_cfg.lz    = lz_sup[k];
        an_sel[k]     = 1'b1;
      end
    end
  end

  seg7_hex_decode u_hex (
    .nib_i   (cur_nib),
    .glyph_o (cur_glyph)
  );

  // Brightness gates both the segments and the anode within each slot.
  always_comb begin
    thresh = ((TH_W'(cur_cfg.bright) + TH_W'(1)) * TH_W'(REFRESH_DIV)) >> 4;
    pwm_on = (TH_W'(cnt_q) < thresh);
    pat    = pwm_on ? seg7_pattern(cur_cfg.blank, cur_cfg.mask, cur_cfg.lz,
                                   cur_cfg.dp, cur_raw, cur_glyph)
                    : 8'h00;
    seg_d  = SEG_ACTIVE_LOW ? (pat ^ SEG_ALL) : pat;
    an_on  = pwm_on ? an_sel : '0;
    an_d   = AN_ACTIVE_LOW ? ~an_on : an_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: default-polarity, inverted-polarity and
// slow-refresh instances share one stimulus stream.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value_i = '0;
  logic [31:0] raw_i = '0;
  logic [3:0]  raw_mask_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic        lz_en_i = 1'b0;
  logic [3:0]  bright_i = '0;
  logic        wr_en_i = 1'b0;

  logic [7:0]  seg_o, seg_inv, seg_64;
  logic [3:0]  an_o, an_inv, an_64;
  logic        frame_o, frame_inv, frame_64;
  logic        busy_o, busy_inv, busy_64;

  int          n_chk = 0;
  int          n_fail = 0;
  int          on_cnt [4];
  logic [3:0]  ea;
  logic [7:0]  es;

  typedef struct packed {
    logic [15:0]     value;
    logic [31:0]     raw;
    logic [3:0]      mask;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0]      bright;
    logic [3:0][7:0] exp;   // lit pattern per digit, {d3,d2,d1,d0}
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(16), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst(rst), .value_i(value_i), .raw_i(raw_i), .raw_mask_i(raw_mask_i),
    .dp_i(dp_i), .blank_i(blank_i), .lz_en_i(lz_en_i), .bright_i(bright_i), .wr_en_i(wr_en_i),
    .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o), .busy_o(busy_o));

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(16), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_inv (
    .clk(clk), .rst(rst), .value_i(value_i), .raw_i(raw_i), .raw_mask_i(raw_mask_i),
    .dp_i(dp_i), .blank_i(blank_i), .lz_en_i(lz_en_i), .bright_i(bright_i), .wr_en_i(wr_en_i),
    .seg_o(seg_inv), .an_o(an_inv), .frame_o(frame_inv), .busy_o(busy_inv));

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(64), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut64 (
    .clk(clk), .rst(rst), .value_i(value_i), .raw_i(raw_i), .raw_mask_i(raw_mask_i),
    .dp_i(dp_i), .blank_i(blank_i), .lz_en_i(lz_en_i), .bright_i(bright_i), .wr_en_i(wr_en_i),
    .seg_o(seg_64), .an_o(an_64), .frame_o(frame_64), .busy_o(busy_64));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the strobe is seen by exactly one rising edge.
  task automatic do_write(input logic [15:0] v, input logic [31:0] r, input logic [3:0] m,
                          input logic [3:0] d, input logic [3:0] b, input logic lz,
                          input logic [3:0] br);
    value_i    = v;
    raw_i      = r;
    raw_mask_i = m;
    dp_i       = d;
    blank_i    = b;
    lz_en_i    = lz;
    bright_i   = br;
    wr_en_i    = 1'b1;
    @(negedge clk);
    wr_en_i    = 1'b0;
  endtask

  // Returns at the negedge right after the edge that applied the pending set.
  task automatic wait_apply(input bit slow, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = slow ? (frame_64 && !busy_64) : (frame_o && !busy_o);
    end
    chk(slow ? "apply_seen_64" : "apply_seen", 32'(ok), 32'd1);
  endtask

  task automatic count_on(input bit slow, input int cycles);
    for (int k = 0; k < 4; k++) on_cnt[k] = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if ((slow ? an_64[k] : an_o[k]) == 1'b0) on_cnt[k]++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h12AF, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 4'hF, 32'h306D7747};
    vecs[1] = '{16'h0005, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b1, 4'hF, 32'h0000005B};
    vecs[2] = '{16'h0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b1, 4'hF, 32'h0000007E};
    vecs[3] = '{16'h3210, 32'h00008000,  4'b0010, 4'b0001, 4'b1000, 1'b0, 4'hF, 32'h006D80FE};
    vecs[4] = '{16'h0305, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b1, 4'hF, 32'h00797E5B};
    vecs[5] = '{16'h0001, 32'h49FF0000,  4'b1100, 4'b0000, 4'b0100, 1'b1, 4'hF, 32'h49000030};
    vecs[6] = '{16'h6789, 32'h0,         4'b0000, 4'b1010, 4'b0000, 1'b0, 4'hF, 32'hDF70FF7B};
    vecs[7] = '{16'hCDE4, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 4'hF, 32'h4E3D4F33};
    vecs[8] = '{16'h0B00, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 4'hF, 32'h7E1F7E7E};

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_o), 32'hFF);
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);
    chk("rst_seg_inv", 32'(seg_inv), 32'h00);
    chk("rst_an_inv", 32'(an_inv), 32'h0);
    chk("rst_busy_inv", 32'(busy_inv), 32'h0);
    chk("rst_frame_inv", 32'(frame_inv), 32'h0);
    chk("rst_seg_64", 32'(seg_64), 32'hFF);
    chk("rst_an_64", 32'(an_64), 32'hF);
    rst = 1'b0;

    // Scan order after release; zero config means 1/16 duty at slot start.
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      ea = (((n - 1) % 16) == 0) ? ~(4'b0001 << (((n - 1) / 16) % 4)) : 4'hF;
      chk($sformatf("scan_an_%0d", n), 32'(an_o), 32'(ea));
      chk($sformatf("scan_frame_%0d", n), 32'(frame_o), ((n % 64) == 0) ? 32'd1 : 32'd0);
    end

    // Table of display settings
    for (int v = 0; v < NV; v++) begin
      do_write(vecs[v].value, vecs[v].raw, vecs[v].mask, vecs[v].dp, vecs[v].blank,
               vecs[v].lz, vecs[v].bright);
      chk($sformatf("v%0d_busy_after_wr", v), 32'(busy_o), 32'd1);
      wait_apply(1'b0, 200);
      for (int k = 0; k < 4; k++) begin
        repeat ((k == 0) ? 1 : 16) @(negedge clk);
        es = ~vecs[v].exp[k];
        ea = ~(4'b0001 << k);
        chk($sformatf("v%0d_seg_d%0d", v, k), 32'(seg_o), 32'(es));
        chk($sformatf("v%0d_an_d%0d", v, k), 32'(an_o), 32'(ea));
        es = vecs[v].exp[k];
        ea = 4'b0001 << k;
        chk($sformatf("v%0d_seg_inv_d%0d", v, k), 32'(seg_inv), 32'(es));
        chk($sformatf("v%0d_an_inv_d%0d", v, k), 32'(an_inv), 32'(ea));
      end
    end

    // Overwrite before apply, then a write on the apply cycle itself
    wait_apply(1'b0, 200);
    do_write(16'h0001, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
    repeat (4) @(negedge clk);
    do_write(16'h0002, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
    repeat (57) @(negedge clk);
    do_write(16'h0003, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
    chk("race_frame", 32'(frame_o), 32'd1);
    chk("race_busy_held", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("race_second_seg", 32'(seg_o), 32'h92);
    chk("race_second_an", 32'(an_o), 32'hE);
    repeat (63) @(negedge clk);
    chk("race_next_frame", 32'(frame_o), 32'd1);
    chk("race_busy_clear", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("race_third_seg", 32'(seg_o), 32'h86);

    // PWM duty
    do_write(16'h0000, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd3);
    wait_apply(1'b1, 600);
    count_on(1'b1, 256);
    for (int k = 0; k < 4; k++) chk($sformatf("pwm64_b3_d%0d", k), 32'(on_cnt[k]), 32'd16);
    do_write(16'h0000, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0);
    wait_apply(1'b1, 600);
    count_on(1'b1, 256);
    for (int k = 0; k < 4; k++) chk($sformatf("pwm64_b0_d%0d", k), 32'(on_cnt[k]), 32'd4);
    do_write(16'h0000, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'd7);
    wait_apply(1'b0, 200);
    count_on(1'b0, 64);
    for (int k = 0; k < 4; k++) chk($sformatf("pwm16_b7_d%0d", k), 32'(on_cnt[k]), 32'd8);

    // Asynchronous reset in the middle of digit 1
    do_write(16'h12AF, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
    wait_apply(1'b0, 200);
    repeat (21) @(negedge clk);
    chk("mid_pre_an", 32'(an_o), 32'hD);
    chk("mid_pre_seg", 32'(seg_o), 32'h88);
    rst = 1'b1;
    #1;
    chk("mid_rst_seg", 32'(seg_o), 32'hFF);
    chk("mid_rst_an", 32'(an_o), 32'hF);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_seg_inv", 32'(seg_inv), 32'h00);
    chk("mid_rst_an_inv", 32'(an_inv), 32'h0);
    @(negedge clk);
    chk("mid_hold_an", 32'(an_o), 32'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_restart_an", 32'(an_o), 32'hE);
    chk("mid_restart_seg", 32'(seg_o), 32'h81);
    chk("mid_restart_busy", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
